// File: rtl/pipeline_control_unit_if.sv
// Handshake bundle between the core datapath/hazard unit and the pipeline control unit.
// master = datapath side (drives status, consumes enables); slave = the control unit.
interface pipeline_control_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              ihit;
    logic              dhit;
    logic              dmem_req;
    logic              load_use;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic              halt_wb;

    logic              pc_en;
    logic              pc_redirect;
    logic [ADDR_W-1:0] pc_target;
    logic              ifid_en;
    logic              idex_en;
    logic              exmem_en;
    logic              memwb_en;
    logic              ifid_flush;
    logic              idex_flush;
    logic              halt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output ihit, dhit, dmem_req, load_use, redirect, redirect_target, halt_wb,
        input  pc_en, pc_redirect, pc_target, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, halt, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, dmem_req, load_use, redirect, redirect_target, halt_wb,
        output pc_en, pc_redirect, pc_target, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, halt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard-unit freezes and redirects
// with I/D cache status into per-latch enables/flushes, and counts stall and flush events.
module pipeline_control_unit #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_control_unit_if.slave ctl
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        RDRAIN = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] target_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;

    logic              mem_stall;
    logic              load_target;
    logic              redirect_accept;

    logic              pc_en;
    logic              pc_redirect;
    logic [ADDR_W-1:0] pc_target;
    logic              ifid_en;
    logic              idex_en;
    logic              exmem_en;
    logic              memwb_en;
    logic              ifid_flush;
    logic              idex_flush;
    logic              halt;

    assign mem_stall = ctl.dmem_req & ~ctl.dhit;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt       = state;
        load_target     = 1'b0;
        redirect_accept = 1'b0;
        pc_en           = 1'b0;
        pc_redirect     = 1'b0;
        pc_target       = '0;
        ifid_en         = 1'b0;
        idex_en         = 1'b0;
        exmem_en        = 1'b0;
        memwb_en        = 1'b0;
        ifid_flush      = 1'b0;
        idex_flush      = 1'b0;
        halt            = 1'b0;

        if (!rst) begin
            pc_target = (state == RDRAIN) ? target_q : ctl.redirect_target;

            case (state)
                RUN, DWAIT: begin
                    if (ctl.halt_wb) begin
                        state_nxt = HALTED;
                    end else if (mem_stall) begin
                        state_nxt = DWAIT;
                    end else if (ctl.redirect) begin
                        redirect_accept = 1'b1;
                        ifid_flush      = 1'b1;
                        idex_flush      = 1'b1;
                        idex_en         = 1'b1;
                        exmem_en        = 1'b1;
                        memwb_en        = 1'b1;
                        if (ctl.ihit) begin
                            pc_en       = 1'b1;
                            pc_redirect = 1'b1;
                            state_nxt   = RUN;
                        end else begin
                            // The fetch in flight is wrong-path; park the target until it returns.
                            load_target = 1'b1;
                            state_nxt   = RDRAIN;
                        end
                    end else if (ctl.load_use) begin
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        state_nxt  = RUN;
                    end else if (!ctl.ihit) begin
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        state_nxt  = RUN;
                    end else begin
                        pc_en     = 1'b1;
                        ifid_en   = 1'b1;
                        idex_en   = 1'b1;
                        exmem_en  = 1'b1;
                        memwb_en  = 1'b1;
                        state_nxt = RUN;
                    end
                end

                RDRAIN: begin
                    if (!mem_stall) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        if (ctl.ihit) begin
                            // The returning word is the stale fetch: drop it and restart at target_q.
                            pc_en       = 1'b1;
                            pc_redirect = 1'b1;
                            state_nxt   = RUN;
                        end
                    end
                end

                HALTED: begin
                    halt = 1'b1;
                end

                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            target_q <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_nxt;
            if (load_target) begin
                target_q <= ctl.redirect_target;
            end
            if (state != HALTED && !pc_en && stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (redirect_accept && flush_q != '1) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign ctl.pc_en       = pc_en;
    assign ctl.pc_redirect = pc_redirect;
    assign ctl.pc_target   = pc_target;
    assign ctl.ifid_en     = ifid_en;
    assign ctl.idex_en     = idex_en;
    assign ctl.exmem_en    = exmem_en;
    assign ctl.memwb_en    = memwb_en;
    assign ctl.ifid_flush  = ifid_flush;
    assign ctl.idex_flush  = idex_flush;
    assign ctl.halt        = halt;
    assign ctl.stall_cnt   = stall_q;
    assign ctl.flush_cnt   = flush_q;

    // EX holds a bubble while draining, so the hazard unit can never resolve a redirect here.
    a_no_redirect_in_rdrain: assert property (
        @(posedge clk) disable iff (rst) !(state == RDRAIN && ctl.redirect)
    );

endmodule
